// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0]         OPC_J        = 6'b000010;
  localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
    logic               valid;
  } if_id_t;

  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return instr[31:26] == OPC_J;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC priority mux: redirect, jump, stall, halt, limit, sequential.
module fetch_next_pc
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_LIMIT = 32'd256
) (
  input  logic            state,
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_hit,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] pc_plus4_c,
  output logic [PC_W-1:0] next_pc_c,
  output logic            next_state_c,
  output logic            flush_c,
  output logic            load_c
);

  assign pc_plus4_c = pc + PC_W'(4);

  always_comb begin
    next_pc_c    = pc;
    next_state_c = state;
    flush_c      = 1'b0;
    load_c       = 1'b0;
    if (br_taken) begin
      next_pc_c    = br_target;
      next_state_c = RUN;
      flush_c      = 1'b1;
    end else if (jmp_hit && !stall) begin
      // delay slot is squashed on the jump
      next_pc_c    = jmp_target;
      next_state_c = RUN;
      flush_c      = 1'b1;
    end else if (stall) begin
      next_pc_c = pc;
    end else if (state == HALT) begin
      flush_c = 1'b1;
    end else if (pc_plus4_c >= PC_LIMIT) begin
      // last word still enters the pipe; pc parks on it
      next_state_c = HALT;
      load_c       = 1'b1;
    end else begin
      next_pc_c = pc_plus4_c;
      load_c    = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, local j resolution, end-of-memory halt.
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC = 32'h0000_0000,
  parameter int unsigned        IM_DEPTH = 64,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [PC_W-1:0]    im_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic               if_id_valid,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(IM_DEPTH * 4);
  localparam if_id_t BUBBLE = '{instr: NOP_WORD, pc4: '0, valid: 1'b0};

  logic [PC_W-1:0] pc;
  fetch_state_e    state;
  if_id_t          if_id_q;

  logic            jmp_hit;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] next_pc;
  logic            next_state;
  logic            flush;
  logic            load;

  assign jmp_hit    = if_id_q.valid && is_jump(if_id_q.instr);
  assign jmp_target = {if_id_q.pc4[31:28], if_id_q.instr[25:0], 2'b00};

  fetch_next_pc #(
    .PC_LIMIT(PC_LIMIT)
  ) u_next_pc (
    .state       (state),
    .pc          (pc),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_hit     (jmp_hit),
    .jmp_target  (jmp_target),
    .pc_plus4_c  (pc_plus4),
    .next_pc_c   (next_pc),
    .next_state_c(next_state),
    .flush_c     (flush),
    .load_c      (load)
  );

  // PC and state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= next_pc;
      state <= fetch_state_e'(next_state);
    end
  end

  // IF/ID pipeline register; holds when neither flush nor load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= BUBBLE;
    end else if (flush) begin
      if_id_q <= BUBBLE;
    end else if (load) begin
      if_id_q <= '{instr: im_instr, pc4: pc_plus4, valid: 1'b1};
    end
  end

  assign im_pc       = pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;
  assign halted      = (state == HALT);

`ifdef FETCH_PERF_EN
  // Saturating counters; a stalled cycle never counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (!stall) begin
      if (load && (perf_fetch_cnt != '1)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (flush && (perf_bubble_cnt != '1)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus random redirects/stalls vs. a rule-level model.
module tb_fetch_stage;

  localparam logic [31:0] CONST_WORD = 32'h2008_0020;
  localparam logic [31:0] LIMIT      = 32'd256;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    bit          valid;
    bit          halted;
    int unsigned fc;
    int unsigned bc;
  } mstate_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] im_instr;
  logic [31:0] im_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          im_mode = 1'b0;
  logic [31:0] imem [64];
  mstate_t     model;
  mstate_t     exp_q [$];

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .im_instr   (im_instr),
    .im_pc      (im_pc),
    .if_id_instr(if_id_instr),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: constant word or table; above the table, a non-jump word
  always_comb begin
    if (!im_mode) im_instr = CONST_WORD;
    else if (im_pc < LIMIT) im_instr = imem[im_pc[7:2]];
    else im_instr = {6'b001000, im_pc[25:0]};
  end

  function automatic logic [31:0] im_word(input logic [31:0] a);
    if (!im_mode) return CONST_WORD;
    if (a < LIMIT) return imem[a / 4];
    return {6'b001000, a[25:0]};
  endfunction

  function automatic mstate_t reset_state();
    mstate_t s;
    s.pc = 32'h0; s.instr = 32'h0; s.pc4 = 32'h0;
    s.valid = 0; s.halted = 0; s.fc = 0; s.bc = 0;
    return s;
  endfunction

  // Rule-level reference: what the stage must hold after one clock
  function automatic mstate_t model_step(input mstate_t s, input bit st, input bit br,
                                         input logic [31:0] tgt);
    mstate_t n = s;
    bit jmp = s.valid && (s.instr[31:26] == 6'b000010);
    bit bubble = 0;
    if (br) begin
      n.pc = tgt; n.halted = 0; bubble = 1;
    end else if (jmp && !st) begin
      n.pc = {s.pc4[31:28], s.instr[25:0], 2'b00}; n.halted = 0; bubble = 1;
    end else if (st) begin
      n = s;
    end else if (s.halted) begin
      bubble = 1;
    end else begin
      n.instr = im_word(s.pc); n.pc4 = s.pc + 32'd4; n.valid = 1; n.fc = s.fc + 1;
      if (s.pc + 32'd4 >= LIMIT) n.halted = 1;
      else n.pc = s.pc + 32'd4;
    end
    if (bubble) begin
      n.instr = 32'h0; n.pc4 = 32'h0; n.valid = 0;
      if (!st) n.bc = s.bc + 1;
    end
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_im_pc"}, im_pc, 32'h0);
    check({tag, "_instr"}, if_id_instr, 32'h0);
    check({tag, "_pc4"}, if_id_pc4, 32'h0);
    check({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    check({tag, "_halted"}, 32'(halted), 32'h0);
`ifdef FETCH_PERF_EN
    check({tag, "_perf_fetch"}, perf_fetch_cnt, 32'h0);
    check({tag, "_perf_bubble"}, perf_bubble_cnt, 32'h0);
`endif
  endtask

  // One clock of stimulus; the expected post-edge state goes to the scoreboard
  task automatic step(input bit st, input bit br, input logic [31:0] tgt);
    @(negedge clk);
    stall = st; br_taken = br; br_target = tgt;
    model = model_step(model, st, br, tgt);
    exp_q.push_back(model);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered update against the oldest expectation
  initial begin
    mstate_t e;
    bit bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        bad = (im_pc !== e.pc) || (if_id_instr !== e.instr) || (if_id_pc4 !== e.pc4) ||
              (if_id_valid !== e.valid) || (halted !== e.halted);
`ifdef FETCH_PERF_EN
        bad = bad || (perf_fetch_cnt !== e.fc) || (perf_bubble_cnt !== e.bc);
`endif
        if (bad) begin
          n_fail++;
          $display("FAIL cycle@%0t: got pc=%h instr=%h pc4=%h v=%b h=%b expected pc=%h instr=%h pc4=%h v=%b h=%b",
                   $time, im_pc, if_id_instr, if_id_pc4, if_id_valid, halted,
                   e.pc, e.instr, e.pc4, e.valid, e.halted);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    for (int i = 0; i < 64; i++) imem[i] = CONST_WORD;
    #3;
    check_reset_values("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("first_fetch_pc", im_pc, 32'h0);
    model = reset_state();

    // sequential run on a constant word
    repeat (4) step(0, 0, 32'h0);
    // stall three cycles at 0x10, then release
    step(0, 1, 32'h10);
    repeat (3) step(1, 0, 32'h0);
    step(0, 0, 32'h0);
    // branch overrides stall
    step(1, 1, 32'h48);
    step(0, 0, 32'h0);

    // j 0x0E at 0x44 -> 0x38, once free-running and once held by a stall
    im_mode = 1'b1;
    imem[6'h11] = 32'h0800_000E;
    step(0, 1, 32'h40);
    repeat (4) step(0, 0, 32'h0);
    step(0, 1, 32'h44);
    step(0, 0, 32'h0);
    repeat (2) step(1, 0, 32'h0);
    repeat (2) step(0, 0, 32'h0);

    // end of memory: halt, bubbles, stall in halt, redirect back to 0
    step(0, 1, 32'hF0);
    repeat (7) step(0, 0, 32'h0);
    step(1, 0, 32'h0);
    step(0, 0, 32'h0);
    step(0, 1, 32'h0);
    repeat (2) step(0, 0, 32'h0);
    // out-of-range redirect target is fetched once, then halts
    step(0, 1, 32'h200);
    repeat (3) step(0, 0, 32'h0);

    // async reset while a jump sits in IF/ID
    step(0, 1, 32'h44);
    step(0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midjump_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_reset_pc", im_pc, 32'h0);
    model = reset_state();
    repeat (2) step(0, 0, 32'h0);

    // random memory with jumps, random stalls and redirects
    for (int i = 0; i < 64; i++)
      imem[i] = ($urandom_range(0, 7) == 0) ? {6'b000010, 20'h0, 6'($urandom_range(0, 63))}
                                             : $urandom;
    for (int k = 0; k < 3000; k++) begin
      bit st = ($urandom_range(0, 3) == 0);
      bit br = ($urandom_range(0, 9) == 0);
      logic [31:0] tgt = ($urandom_range(0, 9) == 0) ? $urandom
                                                     : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      step(st, br, tgt);
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
